// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer that drives a single alu1b slice LSB-first to build a W-bit AND/OR/ADD/SUB.
// Optional zero flag output z is enabled by defining ALU_SERIAL_ZFLAG_EN.
module alu_serial_ctrl #(
    parameter int W = 8,
    localparam int CW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic [2:0]   op_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         co,
    output logic         err,
`ifdef ALU_SERIAL_ZFLAG_EN
    output logic         z,
`endif
    output logic         alu_a,
    output logic         alu_b,
    output logic         alu_ci,
    output logic [2:0]   alu_op,
    input  logic         alu_r,
    input  logic         alu_co
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    // state_q is the observable FSM state for checkers bound to this block.
    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2:0]     op_q;
    logic [CW-1:0]  idx_q;
    logic           carry_q;
    logic [W-1:0]   result_nxt;
    logic           op_legal;
    logic           last_bit;
    logic           arith_op;

    assign op_legal = (op_in == OP_AND) || (op_in == OP_OR) ||
                      (op_in == OP_ADD) || (op_in == OP_SUB);
    assign last_bit = (idx_q == CW'(W - 1));
    assign arith_op = (op_q == OP_ADD) || (op_q == OP_SUB);

    // Handshake: start is taken only in IDLE; busy covers the W slice cycles;
    // done pulses once with result/co/err valid; extra starts while busy are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = op_legal ? S_RUN : S_FIN;
            S_RUN:   if (last_bit) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == S_RUN);
        done   = (state_q == S_FIN);
        alu_a  = 1'b0;
        alu_b  = 1'b0;
        alu_ci = 1'b0;
        alu_op = op_q;
        if (state_q == S_RUN) begin
            alu_a  = a_q[idx_q];
            alu_b  = b_q[idx_q];
            alu_ci = carry_q;
        end
    end

    always_comb begin
        result_nxt        = result;
        result_nxt[idx_q] = alu_r;
    end

    // SUB relies on the slice inverting b; the controller only seeds carry=1 for bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            idx_q   <= '0;
            carry_q <= 1'b0;
            result  <= '0;
            co      <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        result <= '0;
                        co     <= 1'b0;
                        err    <= !op_legal;
                        idx_q  <= '0;
                        if (op_legal) begin
                            a_q     <= a_in;
                            b_q     <= b_in;
                            op_q    <= op_in;
                            carry_q <= (op_in == OP_SUB);
                        end
                    end
                end
                S_RUN: begin
                    result  <= result_nxt;
                    carry_q <= alu_co;
                    if (last_bit) begin
                        idx_q <= '0;
                        co    <= arith_op ? alu_co : 1'b0;
                    end else begin
                        idx_q <= idx_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_SERIAL_ZFLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z <= 1'b0;
        end else if (state_q == S_IDLE && start) begin
            z <= !op_legal;
        end else if (state_q == S_RUN && last_bit) begin
            z <= (result_nxt == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: alu1b slice model, transaction-level reference model,
// per-cycle compare process and directed vectors with literal expectations.
module tb_alu_serial_ctrl;

    localparam int W = 8;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [2:0]   op_in = 3'b000;
    logic         busy, done, co, err;
    logic [W-1:0] result;
    logic         alu_a, alu_b, alu_ci, alu_r, alu_co;
    logic [2:0]   alu_op;
`ifdef ALU_SERIAL_ZFLAG_EN
    logic         z;
`endif

    int errors = 0;
    int checks = 0;

    alu_serial_ctrl #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in), .op_in(op_in),
        .busy(busy), .done(done), .result(result), .co(co), .err(err),
`ifdef ALU_SERIAL_ZFLAG_EN
        .z(z),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci), .alu_op(alu_op),
        .alu_r(alu_r), .alu_co(alu_co)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- alu1b slice ----------------
    logic slice_b;
    assign slice_b = (alu_op == OP_SUB) ? ~alu_b : alu_b;
    always_comb begin
        alu_r  = 1'b0;
        alu_co = 1'b0;
        case (alu_op)
            OP_AND: alu_r = alu_a & alu_b;
            OP_OR:  alu_r = alu_a | alu_b;
            OP_ADD, OP_SUB: begin
                alu_r  = alu_a ^ slice_b ^ alu_ci;
                alu_co = (alu_a & slice_b) | (alu_a & alu_ci) | (slice_b & alu_ci);
            end
            default: ;
        endcase
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // {carry, result} of the full-width operation.
    function automatic logic [W:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
        case (op)
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {(a >= b), a - b};
            default: return '0;
        endcase
    endfunction

    // Carry into bit i of the full-width add (SUB = a + ~b + 1).
    function automatic logic exp_carry_in(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op, input int i);
        logic [63:0] mask, s, aa, bb;
        mask = (64'd1 << i) - 64'd1;
        aa   = {{(64-W){1'b0}}, a} & mask;
        bb   = {{(64-W){1'b0}}, b};
        case (op)
            OP_ADD:  s = aa + (bb & mask);
            OP_SUB:  s = aa + (~bb & mask) + 64'd1;
            default: s = '0;
        endcase
        return s[i];
    endfunction

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    int           m_left = 0;
    logic         m_fin = 1'b0;
    logic [W-1:0] m_res = '0;
    logic         m_co = 1'b0;
    logic         m_err = 1'b0;
    logic         m_z = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [2:0]   m_op = 3'b000;
    logic [W:0]   p_val = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_fin  <= 1'b0;
            m_res  <= '0;
            m_co   <= 1'b0;
            m_err  <= 1'b0;
            m_z    <= 1'b0;
            exp_q.delete();
        end else begin
            m_fin <= 1'b0;
            if (m_left == 0 && !m_fin && start) begin
                m_res <= '0;
                m_co  <= 1'b0;
                if (is_legal(op_in)) begin
                    m_a    <= a_in;
                    m_b    <= b_in;
                    m_op   <= op_in;
                    m_left <= W;
                    m_err  <= 1'b0;
                    m_z    <= 1'b0;
                    p_val  <= model_op(a_in, b_in, op_in);
                    exp_q.push_back(model_op(a_in, b_in, op_in) & {1'b0, {W{1'b1}}});
                end else begin
                    m_fin <= 1'b1;
                    m_err <= 1'b1;
                    m_z   <= 1'b1;
                    exp_q.push_back('0);
                end
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_fin <= 1'b1;
                    m_res <= p_val[W-1:0];
                    m_co  <= p_val[W];
                    m_z   <= (p_val[W-1:0] == '0);
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, m_left > 0);
            check("done", done, m_fin);
            check("err", err, m_err);
            if (m_left == 0) begin
                check("result", result, m_res);
                check("co", co, m_co);
                check("alu_a_idle", alu_a, 1'b0);
                check("alu_b_idle", alu_b, 1'b0);
                check("alu_ci_idle", alu_ci, 1'b0);
`ifdef ALU_SERIAL_ZFLAG_EN
                check("z", z, m_z);
`endif
            end else begin
                check("alu_a", alu_a, m_a[W - m_left]);
                check("alu_b", alu_b, m_b[W - m_left]);
                check("alu_ci", alu_ci, exp_carry_in(m_a, m_b, m_op, W - m_left));
                check("alu_op", alu_op, m_op);
            end
            if (done) begin
                if (exp_q.size() == 0) check("done_unexpected", done, 1'b0);
                else check("sb_result", result, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic [W-1:0] exp_res, input logic exp_co,
                          input logic exp_err, input int exp_lat, input int restart_at);
        int n;
        int busy_n;
        logic ci0;
        @(negedge clk);
        #1;
        start = 1'b1; a_in = a; b_in = b; op_in = op;
        n = 0; busy_n = 0; ci0 = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (n == 1) ci0 = alu_ci;
            #1;
            if (n == restart_at) begin
                start = 1'b1; a_in = ~a; b_in = 8'h5C; op_in = OP_SUB;
            end else begin
                start = 1'b0;
            end
        end while (!done && n < W + 4);
        check({name, "_done_seen"}, done, 1'b1);
        check({name, "_latency"}, n, exp_lat);
        check({name, "_busy_cycles"}, busy_n, exp_lat - 1);
        check({name, "_result"}, result, exp_res);
        check({name, "_co"}, co, exp_co);
        check({name, "_err"}, err, exp_err);
        check({name, "_ci_bit0"}, ci0, (op == OP_SUB));
`ifdef ALU_SERIAL_ZFLAG_EN
        check({name, "_z"}, z, exp_err || (exp_res == '0));
`endif
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b0);
        check({name, "_result"}, result, '0);
        check({name, "_co"}, co, 1'b0);
        check({name, "_err"}, err, 1'b0);
        check({name, "_alu_a"}, alu_a, 1'b0);
        check({name, "_alu_b"}, alu_b, 1'b0);
        check({name, "_alu_ci"}, alu_ci, 1'b0);
        check({name, "_alu_op"}, alu_op, 3'b000);
`ifdef ALU_SERIAL_ZFLAG_EN
        check({name, "_z"}, z, 1'b0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op("add_5a_3c", 8'h5A, 8'h3C, OP_ADD, 8'h96, 1'b0, 1'b0, W + 1, 0);
        run_op("sub_10_01", 8'h10, 8'h01, OP_SUB, 8'h0F, 1'b1, 1'b0, W + 1, 0);
        run_op("sub_01_02", 8'h01, 8'h02, OP_SUB, 8'hFF, 1'b0, 1'b0, W + 1, 0);
        run_op("and_f0_3c", 8'hF0, 8'h3C, OP_AND, 8'h30, 1'b0, 1'b0, W + 1, 0);
        run_op("or_f0_0c",  8'hF0, 8'h0C, OP_OR,  8'hFC, 1'b0, 1'b0, W + 1, 0);
        run_op("illegal_011", 8'hA5, 8'h5A, 3'b011, 8'h00, 1'b0, 1'b1, 1, 0);
        run_op("add_01_01", 8'h01, 8'h01, OP_ADD, 8'h02, 1'b0, 1'b0, W + 1, 0);
        run_op("add_restart", 8'h21, 8'h13, OP_ADD, 8'h34, 1'b0, 1'b0, W + 1, 3);
        run_op("add_ff_ff", 8'hFF, 8'hFF, OP_ADD, 8'hFE, 1'b1, 1'b0, W + 1, 0);

        // Abort an ADD in its fourth RUN cycle.
        @(negedge clk);
        #1;
        start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; op_in = OP_ADD;
        @(negedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        repeat (3) begin
            @(negedge clk);
            check("midrun_no_done", done, 1'b0);
        end
        #1 rst_n = 1'b1;

        run_op("add_ff_01", 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b0, W + 1, 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
Bit-serial sequencer that drives one external 1-bit ALU slice (alu1b: inputs a, b, ci, op[2:0]; outputs r, co) to perform a W-bit operation over W clock cycles. It latches two W-bit operands and an opcode on a start/busy/done handshake. It then steps the slice LSB-first, feeding each bit's carry-out back as the next bit's carry-in, and assembles the W-bit result plus the final carry. It sits between a register file or test driver and the alu1b slice, so the single slice serves as a full-width ALU.

Parameters:
W, 8, operand and result width in bits; legal range 2..32.
CW, $clog2(W), bit-index counter width; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
a_in  in  W  operand A, sampled with start.
b_in  in  W  operand B, sampled with start.
op_in  in  3  opcode, sampled with start: 000 AND, 001 OR, 010 ADD, 110 SUB; all other codes are illegal.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse; result, co and err are valid.
result  out  W  assembled result; held until the next accepted start.
co  out  1  final carry of ADD/SUB (SUB: 1 = no borrow); 0 for AND/OR.
err  out  1  set with done for an illegal opcode; held like result.
alu_a  out  1  to slice a.
alu_b  out  1  to slice b.
alu_ci  out  1  to slice ci.
alu_op  out  3  to slice op.
alu_r  in  1  from slice r (combinational from alu_* drives).
alu_co  in  1  from slice co.

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, co, err = 0. result = 0. alu_a, alu_b, alu_ci = 0. alu_op = 000. Internal carry, index and operand registers cleared.
- States: IDLE, RUN, FIN.
- IDLE -> RUN on start=1 with legal op_in:
  - latch a_in, b_in, op_in; idx = 0.
  - carry = 1 if op_in = 110, else 0.
- IDLE -> FIN on start=1 with illegal op_in: no RUN cycles; result = 0, co = 0, err = 1.
- start in RUN or FIN is ignored; no queueing.
- RUN drives, all registered sources:
  - alu_a = a_q[idx], alu_b = b_q[idx], alu_op = op_q.
  - alu_ci = carry.
  - The slice inverts b for SUB; the controller only supplies ci = 1 at bit 0.
- Each RUN rising edge:
  - result[idx] <= alu_r.
  - carry <= alu_co.
  - idx <= idx + 1.
- On the edge with idx = W-1: go to FIN; co <= alu_co if op is ADD/SUB, else 0.
- Operand bits are never sampled at idx >= W; no wrap-around.
- FIN: done = 1 for exactly one cycle, busy = 0, then -> IDLE.
- Latency: start accepted at edge k -> done high in the cycle after edge k+W (W+1 cycles total). Illegal op -> done the cycle after edge k.
- busy is 1 throughout RUN and 0 in IDLE and FIN.
- err and result are cleared at the next accepted start.
- alu_a, alu_b, alu_ci = 0 outside RUN. alu_op holds op_q.
- Reset mid-operation aborts immediately; no done pulse; all outputs take reset values.

Optional Feature:
ALU_SERIAL_ZFLAG_EN:
- Defined: adds output z (1 bit), registered. Set with done to 1 when result is all zeros, else 0. Held until the next accepted start. Reset value 0. Illegal op gives z = 1.
- Undefined: port z does not exist; no other change.

Test Plan:
- W=8, ADD a=0x5A b=0x3C -> done at start+9 cycles, result=0x96, co=0, err=0, busy high exactly 8 cycles.
- SUB a=0x10 b=0x01 -> result=0x0F, co=1. SUB a=0x01 b=0x02 -> result=0xFF, co=0. alu_ci=1 only on the bit-0 cycle.
- AND a=0xF0 b=0x3C -> result=0x30, co=0. OR a=0xF0 b=0x0C -> result=0xFC, co=0.
- op=011 -> done one cycle after start, err=1, result=0x00, alu_a/alu_b stay 0. Next legal ADD 0x01+0x01 -> result=0x02, err=0.
- start pulsed again at RUN cycle 3 with different operands -> ignored; first result unchanged.
- Assert rst_n=0 at RUN cycle 4 -> outputs zero immediately, no done. After release, ADD 0xFF+0x01 -> result=0x00, co=1. With ZFLAG_EN, z=1.
